// File: rtl/spi_pkg.sv
// Shared SPI definitions: CR1 bit positions, transfer-engine state encoding
// and the baud half-period helper.
package spi_pkg;

   localparam int SPI_DATA_WIDTH = 8;

   localparam int CR1_SPE   = 6;
   localparam int CR1_CPOL  = 3;
   localparam int CR1_CPHA  = 2;
   localparam int CR1_SSOE  = 1;
   localparam int CR1_LSBFE = 0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] LAG   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = IDLE,
      S_SETUP = SETUP,
      S_SHIFT = SHIFT,
      S_LAG   = LAG
   } state_t;

   // HALF = (sppr+1) << spr, 1..1024
   function automatic logic [10:0] half_period(input logic [2:0] sppr, input logic [2:0] spr);
      return (11'(sppr) + 11'd1) << spr;
   endfunction

endpackage

// File: rtl/spi_baud_div.sv
// Reloadable SCK half-period down-counter; half_tick marks the last cycle of
// each HALF-cycle period.
module spi_baud_div
   import spi_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       cfg_load,
   input  logic       load,
   input  logic [2:0] sppr_in,
   input  logic [2:0] spr_in,
   output logic       half_tick
);

   logic [10:0] half_q;
   logic [10:0] cnt_q;
   logic [10:0] half_new;

   assign half_new  = half_period(sppr_in, spr_in);
   assign half_tick = (cnt_q == '0);

   // cfg_load latches a fresh divisor for the frame; load only restarts the count
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         half_q <= 11'd1;
         cnt_q  <= '0;
      end else if (cfg_load) begin
         half_q <= half_new;
         cnt_q  <= half_new - 11'd1;
      end else if (load || half_tick) begin
         cnt_q  <= half_q - 11'd1;
      end else begin
         cnt_q  <= cnt_q - 11'd1;
      end
   end

endmodule

// File: rtl/spi_xfer_engine.sv
// Byte-level SPI transfer engine: holding buffer, frame FSM, SCK generation
// and the MOSI/MISO shift registers.
module spi_xfer_engine
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   input  logic                  cpol_in,
   input  logic                  cpha_in,
   input  logic                  lsbfe_in,
   input  logic [2:0]            sppr_in,
   input  logic [2:0]            spr_in,
   input  logic [DATA_WIDTH-1:0] tx_data_in,
   input  logic                  tx_valid_in,
   output logic                  tx_ready_out,
   output logic [DATA_WIDTH-1:0] rx_data_out,
   output logic                  rx_valid_out,
   output logic                  done_out,
   output logic                  busy_out,
   input  logic                  miso_in,
   output logic                  mosi_out,
   output logic                  sck_out,
   output logic                  ss_out
);

   localparam int            EW        = $clog2(2*DATA_WIDTH + 1);
   localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_WIDTH - 1);

   state_t                state_q;
   logic [DATA_WIDTH-1:0] buf_q;
   logic [DATA_WIDTH-1:0] tx_sh;
   logic [DATA_WIDTH-1:0] rx_sh;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic [EW-1:0]         edge_cnt;
   logic                  tx_ready_q;
   logic                  cpha_q;
   logic                  lsbfe_q;
   logic                  sck_q;
   logic                  mosi_q;
   logic                  ss_q;
   logic                  rx_valid_q;
   logic                  done_q;

   logic half_tick;
   logic wr_acc;
   logic lag_end;
   logic start;
   logic shift_tick;
   logic odd_edge;
   logic last_edge;
   logic do_sample;
   logic do_shift;
   logic baud_load;

   assign wr_acc     = tx_valid_in && tx_ready_q;
   assign lag_end    = (state_q == S_LAG) && half_tick;
   // a write landing in the LAG-end cycle is not visible here yet
   assign start      = enable_in && !tx_ready_q && ((state_q == S_IDLE) || lag_end);
   assign shift_tick = (state_q == S_SHIFT) && half_tick;
   // edge_cnt holds completed toggles, so the coming edge is odd when it is even
   assign odd_edge   = ~edge_cnt[0];
   assign last_edge  = (edge_cnt == LAST_EDGE);
   assign do_sample  = shift_tick && (odd_edge ^ cpha_q);
   assign do_shift   = shift_tick && (cpha_q ? (odd_edge && (edge_cnt != '0))
                                             : (!odd_edge && !last_edge));
   assign baud_load  = half_tick && ((state_q == S_SETUP) || (shift_tick && last_edge));

   spi_baud_div u_baud (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .cfg_load  (start),
      .load      (baud_load),
      .sppr_in   (sppr_in),
      .spr_in    (spr_in),
      .half_tick (half_tick)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         buf_q      <= '0;
         tx_sh      <= '0;
         rx_sh      <= '0;
         rx_data_q  <= '0;
         edge_cnt   <= '0;
         tx_ready_q <= 1'b1;
         cpha_q     <= 1'b0;
         lsbfe_q    <= 1'b0;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         ss_q       <= 1'b1;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         if (!enable_in) begin
            state_q    <= S_IDLE;
            ss_q       <= 1'b1;
            sck_q      <= cpol_in;
            tx_ready_q <= 1'b1;
         end else begin
            if (wr_acc) begin
               buf_q      <= tx_data_in;
               tx_ready_q <= 1'b0;
            end
            if (start) begin
               state_q    <= S_SETUP;
               ss_q       <= 1'b0;
               sck_q      <= cpol_in;
               cpha_q     <= cpha_in;
               lsbfe_q    <= lsbfe_in;
               tx_sh      <= buf_q;
               mosi_q     <= lsbfe_in ? buf_q[0] : buf_q[DATA_WIDTH-1];
               tx_ready_q <= 1'b1;
               edge_cnt   <= '0;
            end
            case (state_q)
               S_IDLE: begin
                  if (!start) begin
                     ss_q  <= 1'b1;
                     sck_q <= cpol_in;
                  end
               end
               S_SETUP: begin
                  if (half_tick) state_q <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (half_tick) begin
                     sck_q    <= ~sck_q;
                     edge_cnt <= edge_cnt + EW'(1);
                     if (do_sample)
                        rx_sh <= lsbfe_q ? {miso_in, rx_sh[DATA_WIDTH-1:1]}
                                         : {rx_sh[DATA_WIDTH-2:0], miso_in};
                     if (do_shift) begin
                        tx_sh  <= lsbfe_q ? (tx_sh >> 1) : (tx_sh << 1);
                        mosi_q <= lsbfe_q ? tx_sh[1] : tx_sh[DATA_WIDTH-2];
                     end
                     if (last_edge) state_q <= S_LAG;
                  end
               end
               S_LAG: begin
                  if (half_tick) begin
                     rx_data_q  <= rx_sh;
                     rx_valid_q <= 1'b1;
                     done_q     <= 1'b1;
                     if (!start) begin
                        state_q <= S_IDLE;
                        ss_q    <= 1'b1;
                        sck_q   <= cpol_in;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign tx_ready_out = tx_ready_q;
   assign rx_data_out  = rx_data_q;
   assign rx_valid_out = rx_valid_q;
   assign done_out     = done_q;
   assign busy_out     = (state_q != S_IDLE);
   assign mosi_out     = mosi_q;
   assign sck_out      = sck_q;
   assign ss_out       = ss_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed and randomized frames against a serial-level slave/observer model.
module tb_spi_xfer_engine;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       enable_in = 1'b0;
   logic       cpol_in = 1'b0, cpha_in = 1'b0, lsbfe_in = 1'b0;
   logic [2:0] sppr_in = 3'd0, spr_in = 3'd0;
   logic [7:0] tx_data_in = 8'd0;
   logic       tx_valid_in = 1'b0;
   logic       tx_ready_out;
   logic [7:0] rx_data_out;
   logic       rx_valid_out, done_out, busy_out;
   logic       miso_in = 1'b0;
   logic       mosi_out, sck_out, ss_out;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int acc_cyc = 0;

   spi_xfer_engine #(.DATA_WIDTH(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
      .cpol_in(cpol_in), .cpha_in(cpha_in), .lsbfe_in(lsbfe_in),
      .sppr_in(sppr_in), .spr_in(spr_in),
      .tx_data_in(tx_data_in), .tx_valid_in(tx_valid_in), .tx_ready_out(tx_ready_out),
      .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .done_out(done_out),
      .busy_out(busy_out), .miso_in(miso_in), .mosi_out(mosi_out),
      .sck_out(sck_out), .ss_out(ss_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave/observer model: counts SCK edges while SS is low, captures MOSI on
   // the master's sampling edges and presents the slave byte in frame order.
   logic       f_cpha = 1'b0, f_lsb = 1'b0;
   logic [7:0] sl_byte = 8'd0;
   logic       prev_sck = 1'b0;
   int         edges = 0, sidx = 0;
   logic [7:0] mosi_acc = 8'd0, last_mosi = 8'd0;
   int         last_edges = 0;

   always @(negedge clk_in) begin
      if (done_out || rx_valid_out) chk("pulse_pair", done_out, rx_valid_out);
      if (done_out) begin
         last_mosi  = mosi_acc;
         last_edges = edges;
      end
      if (rst_in || ss_out || done_out) begin
         edges = 0;
         sidx  = 0;
      end else if (sck_out !== prev_sck) begin
         edges++;
         if (((edges % 2) == 1) != f_cpha) begin
            if (sidx < 8) mosi_acc[f_lsb ? sidx : 7 - sidx] = mosi_out;
            sidx++;
         end
      end
      prev_sck = sck_out;
      miso_in  = (sidx < 8) ? sl_byte[f_lsb ? sidx : 7 - sidx] : 1'b0;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic setcfg(input logic cp, input logic ch, input logic lb,
                         input logic [2:0] pr, input logic [2:0] sr);
      cpol_in = cp; cpha_in = ch; lsbfe_in = lb; sppr_in = pr; spr_in = sr;
      f_cpha = ch; f_lsb = lb;
   endtask

   task automatic push(input logic [7:0] d);
      int n = 0;
      while (!tx_ready_out && n < 4000) begin tick(); n++; end
      chk("push_ready", tx_ready_out, 1'b1);
      tx_data_in  = d;
      tx_valid_in = 1'b1;
      tick();
      acc_cyc     = cyc;
      tx_valid_in = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_cyc, input logic [7:0] exp_rx);
      int n = 0;
      int ss_hi = 0;
      do begin
         tick();
         n++;
         if (!done_out && ss_out) ss_hi++;
      end while (!done_out && n < 4000);
      chk({tag, "_lat"}, cyc, exp_cyc);
      chk({tag, "_rx"}, rx_data_out, exp_rx);
      chk({tag, "_rxv"}, rx_valid_out, 1'b1);
      chk({tag, "_ss_low"}, ss_hi, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sck"}, sck_out, 1'b0);
      chk({tag, "_mosi"}, mosi_out, 1'b0);
      chk({tag, "_ss"}, ss_out, 1'b1);
      chk({tag, "_rdy"}, tx_ready_out, 1'b1);
      chk({tag, "_rx"}, rx_data_out, 8'h00);
      chk({tag, "_rxv"}, rx_valid_out, 1'b0);
      chk({tag, "_done"}, done_out, 1'b0);
      chk({tag, "_busy"}, busy_out, 1'b0);
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic [7:0] sl,
                            input logic cp, input logic ch, input logic lb,
                            input logic [2:0] pr, input logic [2:0] sr);
      int half;
      half = (int'(pr) + 1) << int'(sr);
      setcfg(cp, ch, lb, pr, sr);
      sl_byte = sl;
      push(d);
      tick();
      chk({tag, "_setup_ss"}, ss_out, 1'b0);
      chk({tag, "_setup_busy"}, busy_out, 1'b1);
      chk({tag, "_setup_sck"}, sck_out, cp);
      chk({tag, "_setup_mosi"}, mosi_out, lb ? d[0] : d[7]);
      wait_done(tag, acc_cyc + 1 + 18 * half, sl);
      tick();
      chk({tag, "_mosi_order"}, last_mosi, d);
      chk({tag, "_edges"}, last_edges, 16);
      chk({tag, "_idle_ss"}, ss_out, 1'b1);
      chk({tag, "_idle_sck"}, sck_out, cp);
      chk({tag, "_idle_busy"}, busy_out, 1'b0);
      chk({tag, "_done_1cyc"}, done_out, 1'b0);
   endtask

   initial begin
      int a, nb, nd;
      tick(); tick();
      chk_reset("reset");
      rst_in = 1'b0;
      enable_in = 1'b1;
      tick();

      // basic MSB-first mode 0 loopback, HALF=1
      run_frame("m0", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0);

      // HALF=6, mode 3, LSB-first, independent slave byte
      run_frame("m3", 8'h3C, 8'h81, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1);

      // back-to-back frames, HALF=2
      setcfg(1'b0, 1'b0, 1'b0, 3'd1, 3'd0);
      sl_byte = 8'h11;
      push(8'h11);
      a = acc_cyc;
      repeat (6) tick();
      push(8'h22);
      wait_done("b2b1", a + 1 + 36, 8'h11);
      chk("b2b_rdy_setup", tx_ready_out, 1'b1);
      chk("b2b_ss_held", ss_out, 1'b0);
      chk("b2b_busy", busy_out, 1'b1);
      sl_byte = 8'h22;
      tick();
      chk("b2b1_mosi", last_mosi, 8'h11);
      wait_done("b2b2", a + 1 + 72, 8'h22);
      tick();
      chk("b2b2_mosi", last_mosi, 8'h22);
      chk("b2b2_ss_idle", ss_out, 1'b1);

      // abort at the 7th SCK edge; a pending buffered byte must be discarded
      setcfg(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
      sl_byte = 8'h00;
      push(8'hFF);
      a = acc_cyc;
      while (cyc < a + 3) tick();
      tx_data_in = 8'h33; tx_valid_in = 1'b1;
      tick();
      tx_valid_in = 1'b0;
      chk("abort_buf_full", tx_ready_out, 1'b0);
      while (cyc < a + 9) tick();
      chk("abort_sck_7", sck_out, 1'b0);
      enable_in = 1'b0;
      tick();
      chk("abort_ss", ss_out, 1'b1);
      chk("abort_sck", sck_out, 1'b1);
      chk("abort_busy", busy_out, 1'b0);
      chk("abort_rdy", tx_ready_out, 1'b1);
      chk("abort_rxv", rx_valid_out, 1'b0);
      chk("abort_done", done_out, 1'b0);
      chk("abort_rx_kept", rx_data_out, 8'h22);
      enable_in = 1'b1;
      nb = 0; nd = 0;
      repeat (30) begin
         tick();
         if (busy_out) nb++;
         if (done_out || rx_valid_out) nd++;
      end
      chk("abort_no_restart", nb, 0);
      chk("abort_no_pulse", nd, 0);
      chk("abort_rx_kept2", rx_data_out, 8'h22);

      // asynchronous reset mid-SHIFT, then a normal frame
      setcfg(1'b0, 1'b1, 1'b0, 3'd0, 3'd1);
      sl_byte = 8'h0F;
      push(8'hC3);
      repeat (8) tick();
      chk("pre_rst_busy", busy_out, 1'b1);
      rst_in = 1'b1;
      #2;
      chk_reset("async_rst");
      tick(); tick();
      chk_reset("rst_hold");
      rst_in = 1'b0;
      tick();
      run_frame("post_rst", 8'h5A, 8'hA6, 1'b0, 1'b1, 1'b0, 3'd0, 3'd1);

      // write attempts while the buffer is full are ignored
      setcfg(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
      sl_byte = 8'h11;
      push(8'h11);
      a = acc_cyc;
      push(8'h77);
      tx_data_in = 8'h99; tx_valid_in = 1'b1;
      repeat (8) tick();
      chk("hold_rdy_low", tx_ready_out, 1'b0);
      tx_valid_in = 1'b0;
      wait_done("hold1", a + 19, 8'h11);
      sl_byte = 8'h77;
      tick();
      chk("hold1_mosi", last_mosi, 8'h11);
      wait_done("hold2", a + 19 + 18, 8'h77);
      tick();
      chk("hold2_mosi", last_mosi, 8'h77);
      chk("hold_idle", busy_out, 1'b0);

      // randomized frames
      for (int i = 0; i < 12; i++) begin
         logic [7:0] d, s;
         d = 8'($urandom);
         s = 8'($urandom);
         run_frame($sformatf("rnd%0d", i), d, s,
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   3'($urandom_range(2)), 3'($urandom_range(2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_xfer_engine.md
# spi_xfer_engine

Byte-level SPI transfer engine placed directly downstream of the `spi_master` control core. It owns the SCK baud divider, a one-deep transmit holding buffer, and the MOSI/MISO shift register. It turns a loaded byte into a complete SPI frame (SS, SCK, MOSI, MISO) and reports the received byte plus a completion pulse, which feeds the core's `finished_out` path.

## Interface
Parameters:
- `DATA_WIDTH`, default 8, bits per frame; the engine produces 2*DATA_WIDTH SCK edges per frame.

Ports:
- `clk_in`  in  1  system clock; the block uses one clock only.
- `rst_in`  in  1  asynchronous, active-high reset.
- `enable_in`  in  1  SPE; low aborts and holds the engine idle.
- `cpol_in`, `cpha_in`, `lsbfe_in`  in  1 each  clock polarity, clock phase, LSB-first select.
- `sppr_in`, `spr_in`  in  3 each  baud prescaler and baud exponent.
- `tx_data_in`  in  DATA_WIDTH  byte to send.
- `tx_valid_in`  in  1  request to write the holding buffer.
- `tx_ready_out`  out  1  holding buffer empty (SPTEF).
- `rx_data_out`  out  DATA_WIDTH  last received byte; held until the next frame completes.
- `rx_valid_out`  out  1  one-cycle pulse when `rx_data_out` updates (SPIF).
- `done_out`  out  1  one-cycle frame-complete pulse, coincident with `rx_valid_out`.
- `busy_out`  out  1  high in every state except IDLE.
- `miso_in`  in  1  serial input.
- `mosi_out`, `sck_out`, `ss_out`  out  1 each  SPI outputs; `ss_out` is active-low.

## Operation
- **Half-period:** HALF = (sppr_in+1) << spr_in, range 1..1024, held in an 11-bit counter.
  - `sppr_in`, `spr_in`, `cpol_in`, `cpha_in` and `lsbfe_in` are sampled when the engine enters SETUP.
  - Changes during a frame have no effect.
- **Buffer write:** a write is accepted when `tx_valid_in && tx_ready_out`. The buffer fills and `tx_ready_out` drops on the next edge.
- **States:** IDLE, SETUP, SHIFT, LAG.
  - **IDLE:**
    - `ss_out`=1, `sck_out`=`cpol_in`.
    - If `enable_in` and the buffer is full: move the buffer into the shift register, set `tx_ready_out`=1, go to SETUP.
  - **SETUP** (HALF cycles):
    - `ss_out`=0, `sck_out`=CPOL.
    - `mosi_out` drives the first bit: MSB, or LSB if LSBFE.
    - Then go to SHIFT.
  - **SHIFT:**
    - `sck_out` toggles at the end of each HALF period, 2*DATA_WIDTH toggles in total; an edge counter counts them.
    - CPHA=0: sample MISO on odd edges, shift MOSI on even edges; no shift after the final edge.
    - CPHA=1: shift MOSI on odd edges, sample on even edges; the first odd edge presents the first bit.
    - After the last edge, `sck_out` is back at CPOL; go to LAG.
  - **LAG** (HALF cycles):
    - At its end, update `rx_data_out` and pulse `rx_valid_out` and `done_out`.
    - Buffer full and `enable_in` high: load the next byte and go to SETUP with `ss_out` held low (back-to-back frame).
    - Otherwise go to IDLE.
- **LSB-first:** applies to both the MOSI shift order and the MISO assembly order.
- **Abort:** `enable_in` low in any state gives, on the next edge:
  - state IDLE, `ss_out`=1, `sck_out`=`cpol_in`;
  - holding buffer cleared, `tx_ready_out`=1;
  - no `rx_valid_out` or `done_out` pulse, `rx_data_out` unchanged.
- **Write during LAG end:** a buffer write accepted in the LAG-end cycle is not seen by the LAG decision. The engine goes IDLE, then SETUP one cycle later.

## Timing
- **Reset values:** `sck_out`=0, `mosi_out`=0, `ss_out`=1, `tx_ready_out`=1, `rx_data_out`=0, `rx_valid_out`=0, `done_out`=0, `busy_out`=0, state IDLE.
- **Reset mid-frame:** all outputs return to their reset values immediately, because reset is asynchronous.
- **Frame latency:** let the write be accepted at edge 0.
  - SETUP is entered at edge 1.
  - First SCK toggle at edge 1+2·HALF; last at 1+(2·DATA_WIDTH+1)·HALF.
  - `done_out` at edge 1+(2·DATA_WIDTH+2)·HALF.
- **Back-to-back frames:** the next SETUP starts on the `done_out` edge. `ss_out` stays low, giving a frame period of (2·DATA_WIDTH+2)·HALF.
- **Outputs:** all registered; no combinational path from any input to `mosi_out`, `sck_out` or `ss_out`.

## Structure
- **Shared package `spi_pkg`:**
  - CR1 bit-index constants (SPE, CPOL, CPHA, SSOE, LSBFE).
  - The state encoding: 2-bit localparams IDLE/SETUP/SHIFT/LAG.
  - `DATA_WIDTH` default.
- **Sub-module `spi_baud_div`:**
  - Reloadable 11-bit down-counter computing HALF from sppr/spr.
  - Emits a one-cycle `half_tick`.
  - Restarts on a `load` strobe at each state entry.
- **Remaining logic:** the FSM, edge counter, shift register and holding buffer live in `spi_xfer_engine`.

## Test plan
- sppr=0, spr=0, CPOL=0, CPHA=0, MSB-first, tx 0xA5, MISO looped to MOSI -> `done_out` at edge 19, `rx_data_out`=0xA5, 16 SCK edges, `ss_out` low for edges 1..18.
- sppr=2, spr=1 (HALF=6), CPOL=1, CPHA=1, LSB-first, tx 0x3C, MISO driven 0x81 by slave model -> SCK idles high, 12-cycle SCK period, `rx_data_out`=0x81, MOSI bit order 0,0,1,1,1,1,0,0.
- Two writes, 0x11 then 0x22 (second accepted while first is in SHIFT) -> two `done_out` pulses 18·HALF apart, `ss_out` never high between frames, `tx_ready_out` high again at the second frame's SETUP entry.
- `enable_in` dropped at the 7th SCK edge of a 0xFF frame -> next edge IDLE, `ss_out`=1, `sck_out`=CPOL, no `rx_valid_out`, `rx_data_out` keeps its previous value.
- `rst_in` pulsed mid-SHIFT, then a new 0x5A frame -> all outputs at reset values during reset, and the next frame completes normally with the correct latency.
- `tx_valid_in` held while `tx_ready_out`=0 -> the write is ignored, the buffer is not overwritten, and the original byte is transmitted.
